// File: rtl/xcr_intc_gen2_if.sv
// XCR control-register bus plus the CPU interrupt handshake of xcr_intc_gen2.
interface xcr_intc_gen2_if #(
  parameter int IVT_W = 24
);
  logic [7:0]       cr_din;
  logic [7:0]       cr_dout;
  logic [3:0]       cr_adr;
  logic             cr_we;
  logic             cr_cs;
  logic             irq;
  logic [IVT_W-1:0] ivec_addr;
  logic             irq_ack;
  logic             irq_eoi;

  // CPU side: drives the bus and the handshake, receives the vector.
  modport master (
    output cr_din, cr_adr, cr_we, cr_cs, irq_ack, irq_eoi,
    input  cr_dout, irq, ivec_addr
  );

  // Controller side.
  modport slave (
    input  cr_din, cr_adr, cr_we, cr_cs, irq_ack, irq_eoi,
    output cr_dout, irq, ivec_addr
  );
endinterface

// File: rtl/xcr_intc_gen2.sv
// xcr_intc_gen2: fixed-priority interrupt/exception controller for the LS1u
// core. Level interrupts and edge-captured exceptions compete for one vector;
// a request/ack/eoi handshake blocks new requests while a handler runs.
// Source vectors are widened internally to 16 bits; for NSRC=8 the upper
// halves are held at zero so the "hi" registers ignore writes and read 0.
module xcr_intc_gen2 #(
  parameter int NSRC  = 8,
  parameter int IVT_W = 24
) (
  input  logic                 clk,
  input  logic                 xcp_clr,
  input  logic [NSRC-1:0]      int_src,
  input  logic [NSRC-1:0]      xcp_src,
  xcr_intc_gen2_if.slave       bus
);

  localparam logic [7:0] HI_MASK = (NSRC == 16) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  // Highest set bit index of a 16-bit vector (0 when empty).
  function automatic logic [3:0] hi_idx(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r = 4'(i);
      end
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic             inten_q, inten_d;
  logic [1:0]       ivesiz_q, ivesiz_d;
  logic [7:0]       mcaus_q, mcaus_d;
  logic [23:0]      ivt_q, ivt_d;
  logic [15:0]      inte_q, inte_d;
  logic [15:0]      xcpe_q, xcpe_d;
  logic [15:0]      xcpp_q, xcpp_d;
  logic [15:0]      xcp_prev_q, xcp_prev_d;
  logic             irq_q, irq_d;
  logic [IVT_W-1:0] ivec_q, ivec_d;

  logic [15:0]      int16_s, xcp16_s;
  logic [15:0]      xcpc_clr_s, xcp_set_s;
  logic [15:0]      icand_s;
  logic             any_s, is_xcp_s;
  logic [4:0]       slot_s;
  logic [9:0]       offset_s;
  logic [IVT_W-1:0] vec_s;
  logic [7:0]       rd_s;
  logic             wr_s;

  assign int16_s = 16'(int_src);
  assign xcp16_s = 16'(xcp_src);
  assign wr_s    = bus.cr_cs & bus.cr_we;

  // Register writes and exception pending capture (set beats clear).
  always_comb begin
    inten_d    = inten_q;
    ivesiz_d   = ivesiz_q;
    ivt_d      = ivt_q;
    inte_d     = inte_q;
    xcpe_d     = xcpe_q;
    xcpc_clr_s = 16'h0000;
    if (wr_s) begin
      case (bus.cr_adr)
        4'h0: begin
          inten_d  = bus.cr_din[7];
          ivesiz_d = bus.cr_din[1:0];
        end
        4'h2: ivt_d[7:0]        = bus.cr_din;
        4'h3: ivt_d[15:8]       = bus.cr_din;
        4'h4: ivt_d[23:16]      = bus.cr_din;
        4'h5: inte_d[7:0]       = bus.cr_din;
        4'h6: inte_d[15:8]      = bus.cr_din & HI_MASK;
        4'h7: xcpe_d[7:0]       = bus.cr_din;
        4'h8: xcpe_d[15:8]      = bus.cr_din & HI_MASK;
        4'h9: xcpc_clr_s[7:0]   = bus.cr_din;
        4'hA: xcpc_clr_s[15:8]  = bus.cr_din & HI_MASK;
        default: xcpc_clr_s = 16'h0000;
      endcase
    end else begin
      xcpc_clr_s = 16'h0000;
    end
    xcp_prev_d = xcp16_s;
    xcp_set_s  = xcp16_s & ~xcp_prev_q & xcpe_q;
    xcpp_d     = (xcpp_q & ~xcpc_clr_s) | xcp_set_s;
  end

  // Winner selection: any exception beats any interrupt, highest index wins.
  always_comb begin
    icand_s = int16_s & inte_q;
    any_s   = (|xcpp_q) | (|icand_s);
    if (|xcpp_q) begin
      is_xcp_s = 1'b1;
      slot_s   = {1'b0, hi_idx(xcpp_q)};
    end else begin
      is_xcp_s = 1'b0;
      slot_s   = 5'(NSRC) + {1'b0, hi_idx(icand_s)};
    end
    offset_s = ({5'd0, slot_s} << ivesiz_q) << 2;
    vec_s    = IVT_W'(ivt_q) + IVT_W'(offset_s);
  end

  // Request/ack/eoi handshake: next state and latched request outputs.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    ivec_d  = ivec_q;
    mcaus_d = mcaus_q;
    case (state_q)
      ST_IDLE: begin
        if (inten_q && any_s) begin
          mcaus_d = {is_xcp_s, 2'b00, slot_s};
          ivec_d  = vec_s;
          irq_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          irq_d   = 1'b0;
          state_d = ST_SERV;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERV: begin
        if (bus.irq_eoi) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERV;
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and register flops; xcp_clr clears everything asynchronously.
  always_ff @(posedge clk or posedge xcp_clr) begin
    if (xcp_clr) begin
      state_q    <= ST_IDLE;
      inten_q    <= 1'b0;
      ivesiz_q   <= 2'd0;
      mcaus_q    <= 8'h00;
      ivt_q      <= 24'h000000;
      inte_q     <= 16'h0000;
      xcpe_q     <= 16'h0000;
      xcpp_q     <= 16'h0000;
      xcp_prev_q <= 16'h0000;
      irq_q      <= 1'b0;
      ivec_q     <= '0;
    end else begin
      state_q    <= state_d;
      inten_q    <= inten_d;
      ivesiz_q   <= ivesiz_d;
      mcaus_q    <= mcaus_d;
      ivt_q      <= ivt_d;
      inte_q     <= inte_d;
      xcpe_q     <= xcpe_d;
      xcpp_q     <= xcpp_d;
      xcp_prev_q <= xcp_prev_d;
      irq_q      <= irq_d;
      ivec_q     <= ivec_d;
    end
  end

  // Combinational register read mux; unmapped and write-only addresses read 0.
  always_comb begin
    rd_s = 8'h00;
    case (bus.cr_adr)
      4'h0: rd_s = {inten_q, 5'b00000, ivesiz_q};
      4'h1: rd_s = mcaus_q;
      4'h2: rd_s = ivt_q[7:0];
      4'h3: rd_s = ivt_q[15:8];
      4'h4: rd_s = ivt_q[23:16];
      4'h5: rd_s = inte_q[7:0];
      4'h6: rd_s = inte_q[15:8];
      4'h7: rd_s = xcpe_q[7:0];
      4'h8: rd_s = xcpe_q[15:8];
      4'hB: rd_s = xcpp_q[7:0];
      4'hC: rd_s = xcpp_q[15:8];
      default: rd_s = 8'h00;
    endcase
  end

  assign bus.cr_dout   = rd_s;
  assign bus.irq       = irq_q;
  assign bus.ivec_addr = ivec_q;

endmodule
